// File: rtl/spi_channel_arbiter_pkg.sv
// Shared definitions for the SPI channel arbiter: FSM encoding, key-size codes,
// requester count and small one-hot helpers.
package spi_channel_arbiter_pkg;

  localparam int NUM_REQ = 3;
  localparam int TIMER_W = 10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [3:0] NK4     = 4'b0100;
  localparam logic [3:0] NK6     = 4'b0110;
  localparam logic [3:0] NK8     = 4'b1000;
  localparam logic [3:0] NK_NONE = 4'b0000;

  typedef logic [NUM_REQ-1:0] req_vec_t;

  function automatic logic [3:0] nk_of(input req_vec_t onehot);
    logic [3:0] code;
    case (onehot)
      3'b001:  code = NK4;
      3'b010:  code = NK6;
      3'b100:  code = NK8;
      default: code = NK_NONE;
    endcase
    return code;
  endfunction

  // Non-one-hot input maps to index 2 so the next search restarts at requester 0.
  function automatic logic [1:0] idx_of(input req_vec_t onehot);
    logic [1:0] idx;
    case (onehot)
      3'b001:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd2;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/spi_channel_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: the search starts at the index
// after last_owner and wraps 2->0; the result is one-hot or zero.
module rr_pick3
  import spi_channel_arbiter_pkg::*;
(
  input  req_vec_t   req,
  input  logic [1:0] last_owner,
  output req_vec_t   winner
);

  // Rotating-priority search over the three requesters
  always_comb begin
    winner = 3'b000;
    case (last_owner)
      2'd0: begin
        if (req[1]) begin
          winner = 3'b010;
        end else if (req[2]) begin
          winner = 3'b100;
        end else if (req[0]) begin
          winner = 3'b001;
        end else begin
          winner = 3'b000;
        end
      end
      2'd1: begin
        if (req[2]) begin
          winner = 3'b100;
        end else if (req[0]) begin
          winner = 3'b001;
        end else if (req[1]) begin
          winner = 3'b010;
        end else begin
          winner = 3'b000;
        end
      end
      default: begin
        if (req[0]) begin
          winner = 3'b001;
        end else if (req[1]) begin
          winner = 3'b010;
        end else if (req[2]) begin
          winner = 3'b100;
        end else begin
          winner = 3'b000;
        end
      end
    endcase
  end

endmodule

// File: rtl/spi_channel_arbiter.sv
// Arbitrates three key-size requesters onto one SPI master: round-robin grant,
// start pulse, per-transfer timeout, per-requester result and abort flags.
module spi_channel_arbiter
  import spi_channel_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
)
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       spi_start,
  output logic [3:0] spi_nk,
  input  logic       spi_fin,
  input  logic       spi_pass,
  output logic [2:0] done,
  output logic [2:0] pass_flags,
  output logic [2:0] timeout_err,
  input  logic [3:0] led_sel,
  output logic       led
);

  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] TIMER_MAX  = {TIMER_W{1'b1}};
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state_r;
  req_vec_t           owner_r;
  req_vec_t           grant_r;
  req_vec_t           done_r;
  req_vec_t           pass_flags_r;
  req_vec_t           timeout_err_r;
  logic [1:0]         last_owner_r;
  logic [TIMER_W-1:0] timer_r;
  logic               spi_start_r;
  logic [3:0]         spi_nk_r;
  req_vec_t           winner_s;
  logic               timer_expired_s;
  logic               led_s;

  rr_pick3 u_rr_pick3 (
    .req        (req),
    .last_owner (last_owner_r),
    .winner     (winner_s)
  );

  assign timer_expired_s = (timer_r == TIMER_LAST);

  // Transfer FSM with registered channel outputs and sticky result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      owner_r       <= 3'b000;
      grant_r       <= 3'b000;
      done_r        <= 3'b000;
      pass_flags_r  <= 3'b000;
      timeout_err_r <= 3'b000;
      last_owner_r  <= 2'd2;
      timer_r       <= TIMER_ZERO;
      spi_start_r   <= 1'b0;
      spi_nk_r      <= NK_NONE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 3'b000;
          if (|req) begin
            owner_r     <= winner_s;
            grant_r     <= winner_s;
            spi_nk_r    <= nk_of(winner_s);
            spi_start_r <= 1'b1;
            state_r     <= ST_START;
          end
        end
        ST_START: begin
          spi_start_r <= 1'b0;
          timer_r     <= TIMER_ZERO;
          state_r     <= ST_BUSY;
        end
        ST_BUSY: begin
          // A completion in the last allowed cycle beats the timeout.
          if (spi_fin) begin
            done_r       <= owner_r;
            pass_flags_r <= spi_pass ? (pass_flags_r | owner_r)
                                     : (pass_flags_r & ~owner_r);
            grant_r      <= 3'b000;
            spi_nk_r     <= NK_NONE;
            state_r      <= ST_RELEASE;
          end else if (timer_expired_s) begin
            done_r        <= owner_r;
            timeout_err_r <= timeout_err_r | owner_r;
            pass_flags_r  <= pass_flags_r & ~owner_r;
            grant_r       <= 3'b000;
            spi_nk_r      <= NK_NONE;
            state_r       <= ST_RELEASE;
          end else if (timer_r != TIMER_MAX) begin
            timer_r <= timer_r + TIMER_ONE;
          end
        end
        ST_RELEASE: begin
          done_r       <= 3'b000;
          last_owner_r <= idx_of(owner_r);
          owner_r      <= 3'b000;
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          owner_r     <= 3'b000;
          grant_r     <= 3'b000;
          done_r      <= 3'b000;
          spi_start_r <= 1'b0;
          spi_nk_r    <= NK_NONE;
        end
      endcase
    end
  end

  // Status LED: pass flag of the requester named by led_sel
  always_comb begin
    led_s = 1'b0;
    case (led_sel)
      NK4:     led_s = pass_flags_r[0];
      NK6:     led_s = pass_flags_r[1];
      NK8:     led_s = pass_flags_r[2];
      default: led_s = 1'b0;
    endcase
  end

  assign grant       = grant_r;
  assign spi_start   = spi_start_r;
  assign spi_nk      = spi_nk_r;
  assign done        = done_r;
  assign pass_flags  = pass_flags_r;
  assign timeout_err = timeout_err_r;
  assign led         = led_s;

endmodule

// File: tb/tb_spi_channel_arbiter.sv
// Self-checking bench for spi_channel_arbiter: table of transfers checked
// through a scoreboard queue, plus hand-written reset/boundary sequences.
module tb_spi_channel_arbiter;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] grant;
  logic       spi_start;
  logic [3:0] spi_nk;
  logic       spi_fin = 1'b0;
  logic       spi_pass = 1'b0;
  logic [2:0] done;
  logic [2:0] pass_flags;
  logic [2:0] timeout_err;
  logic [3:0] led_sel = 4'b0000;
  logic       led;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  spi_channel_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .spi_start   (spi_start),
    .spi_nk      (spi_nk),
    .spi_fin     (spi_fin),
    .spi_pass    (spi_pass),
    .done        (done),
    .pass_flags  (pass_flags),
    .timeout_err (timeout_err),
    .led_sel     (led_sel),
    .led         (led)
  );

  // fin_cyc: BUSY cycle (1-based) in which spi_fin is driven; 0 = never (timeout)
  typedef struct {
    logic [2:0] req;
    int         fin_cyc;
    logic       pass;
    logic       drop;
    logic [2:0] grant;
    logic [3:0] nk;
    logic [2:0] done;
    logic [2:0] pflags;
    logic [2:0] terr;
  } vec_t;

  typedef struct {
    logic [2:0] grant;
    logic [3:0] nk;
    logic [2:0] done;
    logic [2:0] pflags;
    logic [2:0] terr;
    int         lat;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   last_start = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = 3'b000; spi_fin = 1'b0; spi_pass = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    last_start = -1;
  endtask

  task automatic run_xfer(input vec_t v);
    exp_t e;
    exp_t got;
    bit   seen;
    int   lat;
    int   slat;
    e.grant = v.grant; e.nk = v.nk; e.done = v.done;
    e.pflags = v.pflags; e.terr = v.terr;
    e.lat = (v.fin_cyc > 0) ? v.fin_cyc + 1 : TO + 1;
    @(negedge clock);
    req = v.req;
    sb_q.push_back(e);
    seen = 0; slat = -1;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (spi_start === 1'b1) begin seen = 1; slat = k; end
    end
    check("start_seen", seen, 1);
    if (!seen) begin
      void'(sb_q.pop_front());
      return;
    end
    check("start_latency", slat, 0);
    check("grant", grant, sb_q[0].grant);
    check("spi_nk", spi_nk, sb_q[0].nk);
    check("done_idle_at_start", done, 3'b000);
    if (last_start >= 0) check("start_gap_ge4", (cyc - last_start) >= 4, 1);
    last_start = cyc;
    seen = 0; lat = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clock);
      if (c == 1) check("start_one_cycle", spi_start, 1'b0);
      if (done !== 3'b000) begin seen = 1; lat = c; end
      if (v.drop && c == 1) req = 3'b000;
      spi_fin  = (!seen && c == v.fin_cyc);
      spi_pass = (!seen && c == v.fin_cyc) ? v.pass : 1'b0;
    end
    spi_fin = 1'b0; spi_pass = 1'b0;
    check("done_seen", seen, 1);
    got = sb_q.pop_front();
    if (seen) begin
      check("done", done, got.done);
      check("done_latency", lat, got.lat);
      check("pass_flags", pass_flags, got.pflags);
      check("timeout_err", timeout_err, got.terr);
      check("release_grant", grant, 3'b000);
      check("release_nk", spi_nk, 4'b0000);
      led_sel = got.nk;
      #1 check("led", led, |(got.pflags & got.grant));
      led_sel = 4'b1111;
      #1 check("led_bad_sel", led, 1'b0);
    end
    if (v.drop) begin
      repeat (3) @(negedge clock);
      check("idle_after_drop", {grant, spi_start}, 4'b0000);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit   seen;
    bit   stray;
    vec_t v;

    vecs[0] = '{3'b001, 5, 1'b1, 1'b0, 3'b001, 4'b0100, 3'b001, 3'b001, 3'b000};
    vecs[1] = '{3'b111, 1, 1'b0, 1'b0, 3'b010, 4'b0110, 3'b010, 3'b001, 3'b000};
    vecs[2] = '{3'b111, 1, 1'b1, 1'b0, 3'b100, 4'b1000, 3'b100, 3'b101, 3'b000};
    vecs[3] = '{3'b111, 2, 1'b1, 1'b0, 3'b001, 4'b0100, 3'b001, 3'b101, 3'b000};
    vecs[4] = '{3'b101, 3, 1'b0, 1'b0, 3'b100, 4'b1000, 3'b100, 3'b001, 3'b000};
    vecs[5] = '{3'b110, 1, 1'b1, 1'b0, 3'b010, 4'b0110, 3'b010, 3'b011, 3'b000};
    vecs[6] = '{3'b011, 4, 1'b0, 1'b0, 3'b001, 4'b0100, 3'b001, 3'b010, 3'b000};
    vecs[7] = '{3'b100, 2, 1'b1, 1'b0, 3'b100, 4'b1000, 3'b100, 3'b110, 3'b000};
    vecs[8] = '{3'b100, 0, 1'b0, 1'b0, 3'b100, 4'b1000, 3'b100, 3'b010, 3'b100};
    vecs[9] = '{3'b010, 6, 1'b0, 1'b1, 3'b010, 4'b0110, 3'b010, 3'b000, 3'b100};

    // Reset state
    repeat (2) @(negedge clock);
    led_sel = 4'b0100;
    #1;
    check("rst_grant", grant, 3'b000);
    check("rst_spi_start", spi_start, 1'b0);
    check("rst_spi_nk", spi_nk, 4'b0000);
    check("rst_done", done, 3'b000);
    check("rst_pass_flags", pass_flags, 3'b000);
    check("rst_timeout_err", timeout_err, 3'b000);
    check("rst_led", led, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_xfer(vecs[i]);
    req = 3'b000;

    // spi_fin and timeout in the same (8th) BUSY cycle: fin wins
    do_reset();
    v = '{3'b100, TO, 1'b1, 1'b0, 3'b100, 4'b1000, 3'b100, 3'b100, 3'b000};
    run_xfer(v);
    req = 3'b000;

    // Reset mid-BUSY: outputs clear, no done pulse, index 0 wins afterwards
    @(negedge clock);
    req = 3'b010;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (spi_start === 1'b1) seen = 1;
    end
    check("abort_start_seen", seen, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_outputs_zero", {grant, spi_start, spi_nk, done, pass_flags, timeout_err}, 17'd0);
    reset = 1'b0; req = 3'b000; last_start = -1;
    stray = 0;
    repeat (4) begin
      @(negedge clock);
      if (done !== 3'b000) stray = 1;
    end
    check("abort_no_done", stray, 1'b0);
    v = '{3'b011, 2, 1'b1, 1'b0, 3'b001, 4'b0100, 3'b001, 3'b001, 3'b000};
    run_xfer(v);
    req = 3'b000;

    // spi_fin outside BUSY is ignored
    @(negedge clock);
    spi_fin = 1'b1; spi_pass = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (done !== 3'b000 || grant !== 3'b000) stray = 1;
    end
    spi_fin = 1'b0;
    @(negedge clock);
    check("idle_fin_ignored", stray, 1'b0);
    check("idle_fin_flags", pass_flags, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
